// File: rtl/link_tx_pkg.sv
// Shared flit definitions for the link transmitter and its bus interface.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package link_tx_pkg;
  localparam int VC_NUM = 4;
  localparam int VC_W   = $clog2(VC_NUM);
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    HEAD      = 2'd0,
    BODY      = 2'd1,
    TAIL      = 2'd2,
    HEAD_TAIL = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t        flit_type;
    logic [VC_W-1:0]   vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

// File: rtl/link_tx_if.sv
// Bus between switch traversal, the link transmitter and the downstream link.
// Latency: n/a (wires only).
// Backpressure: per-VC on/off flags travel upstream alongside the flits.
interface link_tx_if;
  link_tx_pkg::flit_t                      data_i;
  logic                                    valid_flit_i;
  logic [link_tx_pkg::VC_NUM-1:0]          on_off_i;
  link_tx_pkg::flit_t                      flit_o;
  logic                                    valid_flit_o;
  logic [link_tx_pkg::VC_NUM-1:0]          tail_sent_o;
  logic                                    is_full_o;
  logic                                    is_empty_o;
  logic                                    proto_err_o;
  logic                                    overflow_o;

  // Transmitter side.
  modport slave (
    input  data_i, valid_flit_i, on_off_i,
    output flit_o, valid_flit_o, tail_sent_o, is_full_o, is_empty_o,
           proto_err_o, overflow_o
  );

  // Upstream/link side driving flits and flow control.
  modport master (
    output data_i, valid_flit_i, on_off_i,
    input  flit_o, valid_flit_o, tail_sent_o, is_full_o, is_empty_o,
           proto_err_o, overflow_o
  );
endinterface

// File: rtl/link_tx.sv
// Link transmitter: per-VC packet sequencing check, one shared flit FIFO, registered link output.
// Latency: a flit written into an empty FIFO with its VC on is on flit_o one edge later.
// Backpressure: head flit waits while its VC is off (head-of-line); full FIFO drops with overflow_o.
module link_tx
  import link_tx_pkg::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  link_tx_if.slave   bus
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  typedef enum logic {IDLE, ACTIVE} vc_state_t;

  flit_t     mem [BUFFER_SIZE];
  logic [PW-1:0] wr_ptr, rd_ptr;
  vc_state_t vc_state_q [VC_NUM];
  vc_state_t vc_state_d [VC_NUM];

  flit_t     in_flit;
  flit_t     head;
  logic      full, empty, pop, push;
  logic      legal;
  vc_state_t nxt_state;
  logic      proto_err_d, overflow_d;

  assign in_flit = bus.data_i;
  assign head    = mem[rd_ptr[AW-1:0]];
  // Extra pointer bit distinguishes full from empty when the slot indices match.
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop     = !empty && bus.on_off_i[head.vc_id];

  assign bus.is_full_o  = full;
  assign bus.is_empty_o = empty;

  // Sequencing check for the arriving flit's VC, then acceptance against FIFO space.
  always_comb begin
    vc_state_d  = vc_state_q;
    legal       = 1'b0;
    nxt_state   = IDLE;
    push        = 1'b0;
    proto_err_d = 1'b0;
    overflow_d  = 1'b0;
    if (bus.valid_flit_i) begin
      if (vc_state_q[in_flit.vc_id] == IDLE) begin
        case (in_flit.flit_type)
          HEAD:      begin legal = 1'b1; nxt_state = ACTIVE; end
          HEAD_TAIL: begin legal = 1'b1; nxt_state = IDLE;   end
          default:   begin legal = 1'b0; nxt_state = IDLE;   end
        endcase
      end else begin
        case (in_flit.flit_type)
          BODY:      begin legal = 1'b1; nxt_state = ACTIVE; end
          TAIL:      begin legal = 1'b1; nxt_state = IDLE;   end
          default:   begin legal = 1'b0; nxt_state = ACTIVE; end
        endcase
      end
      if (!legal) begin
        proto_err_d = 1'b1;
      end else if (!full || pop) begin
        // A same-cycle pop frees the slot, so a full FIFO can still take the flit.
        push = 1'b1;
        vc_state_d[in_flit.vc_id] = nxt_state;
      end else begin
        // Dropped for space: the VC keeps its state so the sender may retry.
        overflow_d = 1'b1;
      end
    end
  end

  // Pointers and VC sequencing state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < VC_NUM; i++) vc_state_q[i] <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      vc_state_q <= vc_state_d;
    end
  end

  // Flit storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_flit;
  end

  // Registered link output and single-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.flit_o       <= '0;
      bus.valid_flit_o <= 1'b0;
      bus.tail_sent_o  <= '0;
      bus.proto_err_o  <= 1'b0;
      bus.overflow_o   <= 1'b0;
    end else begin
      bus.valid_flit_o <= pop;
      bus.tail_sent_o  <= '0;
      bus.proto_err_o  <= proto_err_d;
      bus.overflow_o   <= overflow_d;
      if (pop) begin
        bus.flit_o <= head;
        if (head.flit_type == TAIL || head.flit_type == HEAD_TAIL)
          bus.tail_sent_o[head.vc_id] <= 1'b1;
      end
    end
  end

endmodule
